// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

    // Pointer width for a power-of-two buffer depth (minimum 1 bit).
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : In-order allocate/fill/pop circular buffer with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    output logic [PW:0]     alloc_cnt,
    output logic [PW:0]     unfilled_cnt,
    output fetch_entry_t    head
);

    fetch_entry_t  r_entries [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_fill_ptr;
    logic [PW:0]   r_alloc_cnt;
    logic [PW:0]   r_unfilled_cnt;
    logic          w_fill_ok;

    // A response with no unfilled entry waiting has nowhere to go.
    assign w_fill_ok = fill && (r_unfilled_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_fill_ptr     <= '0;
            r_alloc_cnt    <= '0;
            r_unfilled_cnt <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].filled <= 1'b0;
            end
            r_tail         <= r_head;
            r_fill_ptr     <= r_head;
            r_alloc_cnt    <= '0;
            r_unfilled_cnt <= '0;
        end else begin
            if (alloc) begin
                r_entries[r_tail].pc     <= alloc_pc;
                r_entries[r_tail].filled <= 1'b0;
                r_tail                   <= r_tail + 1'b1;
            end
            if (w_fill_ok) begin
                r_entries[r_fill_ptr].instr  <= fill_data;
                r_entries[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr                   <= r_fill_ptr + 1'b1;
            end
            // Clearing filled on pop keeps an empty head slot from looking valid.
            if (pop) begin
                r_entries[r_head].filled <= 1'b0;
                r_head                   <= r_head + 1'b1;
            end
            r_alloc_cnt    <= r_alloc_cnt + (PW+1)'(alloc) - (PW+1)'(pop);
            r_unfilled_cnt <= r_unfilled_cnt + (PW+1)'(alloc) - (PW+1)'(w_fill_ok);
        end
    end

    assign alloc_cnt    = r_alloc_cnt;
    assign unfilled_cnt = r_unfilled_cnt;
    assign head         = r_entries[r_head];

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Fetch PC, imem request logic and wrong-path drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out
);

    localparam int c_ptr_w = ptr_width(FIFO_DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [c_ptr_w:0]   r_drop_cnt;
    logic [c_ptr_w:0]   w_alloc_cnt;
    logic [c_ptr_w:0]   w_unfilled_cnt;
    logic [c_ptr_w+1:0] w_occupancy;
    fetch_entry_t       w_head;
    logic               w_grant;
    logic               w_drop_hit;
    logic               w_fill;
    logic               w_rsp_used;
    logic               w_pop;
    logic [1:0]         w_unused_redirect_lsb;

    assign w_unused_redirect_lsb = redirect_pc[1:0];

    // Stale in-flight responses still occupy capacity until they return.
    assign w_occupancy = {1'b0, w_alloc_cnt} + {1'b0, r_drop_cnt};
    assign imem_req    = !rst && !redirect_valid &&
                         (w_occupancy < (c_ptr_w+2)'(FIFO_DEPTH));
    assign imem_addr   = r_fetch_pc;
    assign w_grant     = imem_req && imem_gnt;

    assign w_drop_hit  = imem_rvalid && (r_drop_cnt != '0);
    assign w_fill      = imem_rvalid && (r_drop_cnt == '0);
    assign w_rsp_used  = w_drop_hit || (w_fill && (w_unfilled_cnt != '0));

    assign if_valid    = w_head.filled && !redirect_valid;
    assign w_pop       = if_valid && !stall_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_drop_cnt <= r_drop_cnt + w_unfilled_cnt - (c_ptr_w+1)'(w_rsp_used);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_drop_cnt <= r_drop_cnt - (c_ptr_w+1)'(w_drop_hit);
        end
    end

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH),
        .PW    (c_ptr_w)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect_valid),
        .alloc        (w_grant),
        .alloc_pc     (r_fetch_pc),
        .fill         (w_fill),
        .fill_data    (imem_rdata),
        .pop          (w_pop),
        .alloc_cnt    (w_alloc_cnt),
        .unfilled_cnt (w_unfilled_cnt),
        .head         (w_head)
    );

    assign pc_out       = w_head.pc;
    assign pc_plus4_out = w_head.pc + 32'd4;
    assign instr_out    = if_valid ? w_head.instr : NOP_INSTR;

    a_no_spurious_rsp : assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((r_drop_cnt != '0) || (w_unfilled_cnt != '0)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;
    localparam logic [31:0] c_key = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;

    logic        mem_hold;
    logic [31:0] rsp_q [$];
    int          n_cmp;
    int          n_fail;

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out),
        .instr_out      (instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: one in-order response per cycle, one cycle after the grant.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                rsp_q.delete();
                imem_rvalid = 1'b0;
            end else if (!mem_hold && rsp_q.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rsp_q.pop_front() ^ c_key;
            end else begin
                imem_rvalid = 1'b0;
            end
            #1;
            if (!rst && imem_req && imem_gnt) rsp_q.push_back(imem_addr);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; mem_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #4;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", if_valid); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc_out); end
        n_cmp++; if (pc_plus4_out !== 32'h4) begin n_fail++; $display("FAIL rst_pc4 got %h want 4", pc_plus4_out); end
        n_cmp++; if (instr_out !== c_nop) begin n_fail++; $display("FAIL rst_instr got %h want %h", instr_out, c_nop); end
        @(negedge clk);
        rst = 1'b0;
        #4;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_addr got %h want 0", imem_addr); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid got %b want 0", if_valid); end
        n_cmp++; if (instr_out !== c_nop) begin n_fail++; $display("FAIL rel_instr got %h want %h", instr_out, c_nop); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            n_cmp++; if (imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL stream_addr c%0d got %h want %h", i, imem_addr, 32'(4*i)); end
            n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req c%0d got %b want 1", i, imem_req); end
            if (i < 2) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fillwait c%0d got %b want 0", i, if_valid); end
            end else begin
                exp_pc = 32'(4*(i-2));
                n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c%0d got %b want 1", i, if_valid); end
                n_cmp++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL stream_pc c%0d got %h want %h", i, pc_out, exp_pc); end
                n_cmp++; if (pc_plus4_out !== exp_pc + 32'd4) begin n_fail++; $display("FAIL stream_pc4 c%0d got %h want %h", i, pc_plus4_out, exp_pc + 32'd4); end
                n_cmp++; if (instr_out !== (exp_pc ^ c_key)) begin n_fail++; $display("FAIL stream_instr c%0d got %h want %h", i, instr_out, exp_pc ^ c_key); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            stall_in = (i >= 4 && i <= 8);
            #4;
            if (i >= 2) begin
                if (i < 4)       exp_pc = 32'(4*(i-2));
                else if (i <= 9) exp_pc = 32'h8;
                else             exp_pc = 32'(8 + 4*(i-9));
                n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d got %b want 1", i, if_valid); end
                n_cmp++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL stall_pc c%0d got %h want %h", i, pc_out, exp_pc); end
                n_cmp++; if (instr_out !== (exp_pc ^ c_key)) begin n_fail++; $display("FAIL stall_instr c%0d got %h want %h", i, instr_out, exp_pc ^ c_key); end
                n_cmp++; if (imem_req !== !(i >= 6 && i <= 9)) begin n_fail++; $display("FAIL stall_req c%0d got %b want %b", i, imem_req, !(i >= 6 && i <= 9)); end
            end
        end
        stall_in = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            mem_hold       = (i <= 2);
            redirect_valid = (i == 2);
            redirect_pc    = 32'h100;
            #4;
            if (i == 2) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b want 0", imem_req); end
            end
            if (i == 3) begin
                n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %h want 100", imem_addr); end
                n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_resume got %b want 1", imem_req); end
            end
            if (i >= 2 && i <= 5) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop c%0d got %b want 0", i, if_valid); end
            end
            if (i >= 6) begin
                n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid c%0d got %b want 1", i, if_valid); end
                n_cmp++; if (pc_out !== 32'(32'h100 + 4*(i-6))) begin n_fail++; $display("FAIL redir_pc c%0d got %h want %h", i, pc_out, 32'(32'h100 + 4*(i-6))); end
                n_cmp++; if (instr_out !== (32'(32'h100 + 4*(i-6)) ^ c_key)) begin n_fail++; $display("FAIL redir_instr c%0d got %h", i, instr_out); end
            end
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            stall_in       = (i == 4);
            redirect_valid = (i == 4);
            redirect_pc    = 32'h203;
            #4;
            if (i == 4) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b want 0", if_valid); end
                n_cmp++; if (instr_out !== c_nop) begin n_fail++; $display("FAIL rs_instr got %h want %h", instr_out, c_nop); end
                n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_req got %b want 0", imem_req); end
            end
            if (i == 5) begin
                n_cmp++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_addr got %h want 200", imem_addr); end
                n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rs_resume got %b want 1", imem_req); end
            end
            if (i == 5 || i == 6) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_flush c%0d got %b want 0", i, if_valid); end
            end
            if (i >= 7) begin
                n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rs_new_valid c%0d got %b want 1", i, if_valid); end
                n_cmp++; if (pc_out !== 32'(32'h200 + 4*(i-7))) begin n_fail++; $display("FAIL rs_pc c%0d got %h want %h", i, pc_out, 32'(32'h200 + 4*(i-7))); end
            end
        end
        n_cmp++; if (instr_out !== 32'hA5A5_0204) begin n_fail++; $display("FAIL rs_instr_last got %h want a5a50204", instr_out); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            redirect_valid = (i == 2);
            redirect_pc    = 32'hFFFF_FFFC;
            #4;
            if (i == 3) begin
                n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr); end
            end
            if (i == 4) begin
                n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", imem_addr); end
            end
            if (i == 5) begin
                n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", if_valid); end
                n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", pc_out); end
                n_cmp++; if (pc_plus4_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 0", pc_plus4_out); end
                n_cmp++; if (instr_out !== 32'h5A5A_FFFC) begin n_fail++; $display("FAIL wrap_instr got %h want 5a5afffc", instr_out); end
            end
            if (i == 6) begin
                n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc got %h want 0", pc_out); end
                n_cmp++; if (pc_plus4_out !== 32'h4) begin n_fail++; $display("FAIL wrap_next_pc4 got %h want 4", pc_plus4_out); end
            end
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got %b want 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", if_valid); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc got %h want 0", pc_out); end
        n_cmp++; if (pc_plus4_out !== 32'h4) begin n_fail++; $display("FAIL mid_rst_pc4 got %h want 4", pc_plus4_out); end
        n_cmp++; if (instr_out !== c_nop) begin n_fail++; $display("FAIL mid_rst_instr got %h want %h", instr_out, c_nop); end
        @(negedge clk);
        rst = 1'b0;
        #4;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_rst_req got %b want 1", imem_req); end
        @(negedge clk);
        #4;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_replay got %b want 0", if_valid); end
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        mem_hold       = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
